// File: rtl/shift_seq_ctrl.sv
// Load sequencer and self-checker for a WIDTH-stage serial-in shift register.
// Latency: accept edge T0, WIDTH shift cycles, one capture cycle, out_valid at T0+WIDTH+2.
// Backpressure: in_ready only in IDLE; result held with out_valid until out_ready.
module shift_seq_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             shift_en,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] held, held_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ser_nxt;
    logic [WIDTH-1:0] in_ord;
    logic [WIDTH-1:0] rest;

    // held is kept in send order: bit WIDTH-1 goes out first, so it is also
    // exactly the word the far-to-near taps should show after the shift.
    always_comb begin
        in_ord = in_data;
        if (!MSB_FIRST) in_ord = {<<{in_data}};
    end

    assign rest = held << (cnt + 1'b1);

    always_comb begin
        state_nxt = state;
        held_nxt  = held;
        cnt_nxt   = cnt;
        ser_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    held_nxt  = in_ord;
                    cnt_nxt   = '0;
                    ser_nxt   = in_ord[WIDTH-1];
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    ser_nxt = rest[WIDTH-1];
                end
            end
            CAPTURE: state_nxt = HOLD;
            HOLD: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            held     <= '0;
            cnt      <= '0;
            ser_out  <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            held    <= held_nxt;
            cnt     <= cnt_nxt;
            ser_out <= ser_nxt;
            if (state == CAPTURE) begin
                out_data <= taps;
                out_err  <= (taps != held);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign shift_en  = (state == SHIFT);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: MSB-first and LSB-first instances, each driving a
// modelled serial-in shift register, with a queue-based output scoreboard.
module tb_shift_seq_ctrl;

    typedef struct packed {
        logic [3:0] d;
        logic       e;
    } exp_t;

    logic       clock;
    logic       clear;
    logic       force_cap;

    logic [3:0] in_data_a, in_data_b;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic       ser_out_a, ser_out_b;
    logic       shift_en_a, shift_en_b;
    logic [3:0] taps_a, taps_b;
    logic [3:0] out_data_a, out_data_b;
    logic       out_err_a, out_err_b;
    logic       out_valid_a, out_valid_b;
    logic       out_ready_a, out_ready_b;
    logic       busy_a, busy_b;

    logic [3:0] sr_a = 4'b0000;
    logic [3:0] sr_b = 4'b0000;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   acc_a[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    shift_seq_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clock(clock), .clear(clear),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .ser_out(ser_out_a), .shift_en(shift_en_a), .taps(taps_a),
        .out_data(out_data_a), .out_err(out_err_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .busy(busy_a)
    );

    shift_seq_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clock(clock), .clear(clear),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .ser_out(ser_out_b), .shift_en(shift_en_b), .taps(taps_b),
        .out_data(out_data_b), .out_err(out_err_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .busy(busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running serial-in register: taps[0] is nearest the input.
    always @(posedge clock) begin
        sr_a <= {sr_a[2:0], ser_out_a};
        sr_b <= {sr_b[2:0], ser_out_b};
        cyc  <= cyc + 1;
    end

    // Fault injection: zero the taps only during instance A's capture cycle.
    assign taps_a = (force_cap && busy_a && !shift_en_a && !out_valid_a) ? 4'b0000 : sr_a;
    assign taps_b = sr_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (clear && in_valid_a && in_ready_a) acc_a.push_back(cyc);
        if (clear && out_valid_a && out_ready_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_output actual=%b required=none", out_data_a);
            end else begin
                ea = qa.pop_front();
                chk("a_out_data", 32'(out_data_a), 32'(ea.d));
                chk("a_out_err", 32'(out_err_a), 32'(ea.e));
            end
        end
        if (clear && out_valid_b && out_ready_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_output actual=%b required=none", out_data_b);
            end else begin
                eb = qb.pop_front();
                chk("b_out_data", 32'(out_data_b), 32'(eb.d));
                chk("b_out_err", 32'(out_err_b), 32'(eb.e));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns one cycle after the accept edge, i.e. in SHIFT cycle 0.
    task automatic send_a(input logic [3:0] d, input logic [3:0] xd, input logic xe);
        in_data_a  = d;
        in_valid_a = 1'b1;
        for (int i = 0; i < 50 && !in_ready_a; i++) step();
        chk("a_in_ready_wait", 32'(in_ready_a), 32'd1);
        qa.push_back(exp_t'({xd, xe}));
        step();
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] d, input logic [3:0] xd, input logic xe);
        in_data_b  = d;
        in_valid_b = 1'b1;
        for (int i = 0; i < 50 && !in_ready_b; i++) step();
        chk("b_in_ready_wait", 32'(in_ready_b), 32'd1);
        qb.push_back(exp_t'({xd, xe}));
        step();
        in_valid_b = 1'b0;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 50 && busy_a; i++) step();
        chk("a_done", 32'(busy_a), 32'd0);
    endtask

    task automatic wait_idle_b();
        for (int i = 0; i < 50 && busy_b; i++) step();
        chk("b_done", 32'(busy_b), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] sh;
        int         n;

        clear       = 1'b0;
        force_cap   = 1'b0;
        in_data_a   = 4'b0000;
        in_data_b   = 4'b0000;
        in_valid_a  = 1'b0;
        in_valid_b  = 1'b0;
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;

        #2;
        chk("rst_ser_out", 32'(ser_out_a), 32'd0);
        chk("rst_shift_en", 32'(shift_en_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_err", 32'(out_err_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_out_data", 32'(out_data_a), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);

        // MSB first, 1011: bits 1,0,1,1 then capture, out_valid at T0+6.
        send_a(4'b1011, 4'b1011, 1'b0);
        sh = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            chk("a_msb_ser_out", 32'(ser_out_a), 32'(sh[3]));
            chk("a_msb_shift_en", 32'(shift_en_a), 32'd1);
            sh = sh << 1;
            step();
        end
        chk("a_cap_shift_en", 32'(shift_en_a), 32'd0);
        chk("a_cap_ser_out", 32'(ser_out_a), 32'd0);
        chk("a_cap_out_valid", 32'(out_valid_a), 32'd0);
        step();
        chk("a_out_valid_t6", 32'(out_valid_a), 32'd1);
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
        chk("a_in_ready_after", 32'(in_ready_a), 32'd1);

        // LSB first, 0001: bits 1,0,0,0; far-first taps read 1000.
        send_b(4'b0001, 4'b1000, 1'b0);
        sh = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            chk("b_lsb_ser_out", 32'(ser_out_b), 32'(sh[0]));
            chk("b_lsb_shift_en", 32'(shift_en_b), 32'd1);
            sh = sh >> 1;
            step();
        end
        out_ready_b = 1'b1;
        wait_idle_b();
        send_b(4'b0011, 4'b1100, 1'b0);
        wait_idle_b();
        out_ready_b = 1'b0;

        // Corrupted capture must be reported through out_err.
        force_cap   = 1'b1;
        out_ready_a = 1'b1;
        send_a(4'b1111, 4'b0000, 1'b1);
        wait_idle_a();
        force_cap   = 1'b0;
        out_ready_a = 1'b0;

        // Output stall: result stable, new words refused.
        send_a(4'b0110, 4'b0110, 1'b0);
        for (int i = 0; i < 20 && !out_valid_a; i++) step();
        chk("a_stall_valid_rise", 32'(out_valid_a), 32'd1);
        in_data_a  = 4'b0101;
        in_valid_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("a_stall_out_valid", 32'(out_valid_a), 32'd1);
            chk("a_stall_out_data", 32'(out_data_a), 32'(4'b0110));
            chk("a_stall_in_ready", 32'(in_ready_a), 32'd0);
            step();
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
        chk("a_stall_release_in_ready", 32'(in_ready_a), 32'd1);
        chk("a_stall_release_busy", 32'(busy_a), 32'd0);

        // Reset during SHIFT cycle 2 abandons the word.
        send_a(4'b1010, 4'b1010, 1'b0);
        step();
        step();
        chk("a_mid_ser_out", 32'(ser_out_a), 32'd1);
        clear = 1'b0;
        #1;
        chk("a_clr_ser_out", 32'(ser_out_a), 32'd0);
        chk("a_clr_shift_en", 32'(shift_en_a), 32'd0);
        chk("a_clr_out_valid", 32'(out_valid_a), 32'd0);
        chk("a_clr_busy", 32'(busy_a), 32'd0);
        chk("a_clr_out_data", 32'(out_data_a), 32'd0);
        chk("a_clr_out_err", 32'(out_err_a), 32'd0);
        void'(qa.pop_back());
        step();
        @(negedge clock);
        clear       = 1'b1;
        out_ready_a = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("a_clr_no_output", 32'(out_valid_a), 32'd0);
            step();
        end
        send_a(4'b1001, 4'b1001, 1'b0);
        wait_idle_a();

        // Back-to-back words with out_ready held: accepts exactly 7 cycles apart.
        in_data_a  = 4'b1100;
        in_valid_a = 1'b1;
        for (int i = 0; i < 50 && !in_ready_a; i++) step();
        chk("a_b2b_ready1", 32'(in_ready_a), 32'd1);
        qa.push_back(exp_t'({4'b1100, 1'b0}));
        step();
        in_data_a = 4'b0011;
        qa.push_back(exp_t'({4'b0011, 1'b0}));
        for (int i = 0; i < 20 && !in_ready_a; i++) step();
        chk("a_b2b_ready2", 32'(in_ready_a), 32'd1);
        step();
        in_valid_a = 1'b0;
        wait_idle_a();
        out_ready_a = 1'b0;
        n = acc_a.size();
        if (n >= 2) chk("a_b2b_interval", 32'(acc_a[n-1] - acc_a[n-2]), 32'd7);
        else chk("a_b2b_accept_count", 32'(n), 32'd2);

        step();
        step();
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Controller that sequences a WIDTH-stage serial-in shift register, such as the team's shiftreg_4bit. It accepts a parallel word on a valid/ready handshake and drives it onto the register's serial input one bit per clock. After the last bit it captures the register's parallel taps and returns the captured word on an output handshake. It also checks the captured word against the word it sent and flags any mismatch, so it serves both as a load sequencer and as a built-in checker for the register.

Parameters:
WIDTH, 4, word length; equals the number of shift-register stages.
MSB_FIRST, 1, 1 = send in_data[WIDTH-1] first; 0 = send in_data[0] first.

Ports:
clock  input  1  rising-edge clock, shared with the shift register.
clear  input  1  asynchronous active-low reset.
in_data  input  WIDTH  word to load.
in_valid  input  1  in_data is valid.
in_ready  output  1  controller can accept a word.
ser_out  output  1  registered bit; drives the shift register serial input.
shift_en  output  1  high during cycles in which ser_out carries a payload bit.
taps  input  WIDTH  shift-register parallel outputs; taps[WIDTH-1] is the stage farthest from the input.
out_data  output  WIDTH  captured tap word.
out_err  output  1  captured word differs from the word sent; valid with out_valid.
out_valid  output  1  out_data and out_err are valid.
out_ready  input  1  consumer accepts the output.
busy  output  1  state is not IDLE.

Behaviour:
- Reset (clear=0, asynchronous):
  - state goes to IDLE.
  - ser_out, shift_en, out_valid, out_err and busy are 0.
  - out_data, the held word and the bit counter are 0.
  - in_ready is 1 after release.
  - Reset asserted mid-operation abandons the word with no output.
- States:
  - IDLE: in_ready=1. On in_valid=1 at a clock edge, latch in_data into the held word, clear the counter and go to SHIFT.
  - SHIFT: lasts exactly WIDTH cycles. In cycle k (k=0..WIDTH-1):
    - ser_out = held[WIDTH-1-k] when MSB_FIRST=1, or held[k] when MSB_FIRST=0.
    - shift_en = 1.
    - The shift register samples ser_out at the edge that ends the cycle.
    - After cycle WIDTH-1, go to CAPTURE.
  - CAPTURE: one cycle; ser_out=0 and shift_en=0.
    - At the edge ending this cycle, register out_data <= taps.
    - Register out_err <= (taps != expected). expected[WIDTH-1-k] = bit sent in SHIFT cycle k, i.e. the first bit sent is expected in the farthest stage.
    - Go to HOLD.
  - HOLD: out_valid=1, with out_data and out_err stable. On out_ready=1 at an edge, go to IDLE.
- Latency:
  - Accept edge at T0.
  - SHIFT occupies cycles T0+1..T0+WIDTH.
  - CAPTURE is cycle T0+WIDTH+1.
  - out_valid rises at T0+WIDTH+2.
  - Minimum interval between accepts is WIDTH+3 cycles.
- Handshakes:
  - in_ready is 1 only in IDLE. in_valid in any other state is ignored and no word is lost from the controller's side; the producer must hold it.
  - out_valid stays high until out_ready. out_ready while out_valid=0 has no effect.
  - out_ready and in_valid high in the same HOLD cycle: HOLD goes to IDLE; the new word is accepted at the next edge.
- ser_out is 0 outside SHIFT, so the register flushes zeros while idle.
- busy = (state != IDLE).
- Bit counter width is clog2(WIDTH)+1. It never wraps inside SHIFT.

Test Plan:
- WIDTH=4, MSB_FIRST=1, in_data=4'b1011 accepted at T0 -> ser_out 1,0,1,1 in cycles T0+1..T0+4 with shift_en=1; out_valid at T0+6; out_data=4'b1011; out_err=0.
- MSB_FIRST=0, in_data=4'b0001 -> ser_out 1,0,0,0; out_data=4'b1000; out_err=0.
- Bench forces taps=4'b0000 during CAPTURE for sent word 4'b1111 -> out_data=4'b0000, out_err=1.
- out_ready held 0 for 10 cycles -> out_valid and out_data stay stable and in_ready=0 throughout; out_ready=1 for one cycle -> IDLE, in_ready=1 next cycle.
- clear pulsed low during SHIFT cycle 2 -> all outputs 0 immediately; no out_valid afterwards; the next word completes normally.
- Back-to-back words 4'b1100 then 4'b0011 with in_valid and out_ready held 1 -> accepts exactly 7 cycles apart; both outputs correct with out_err=0.
